// File: rtl/seg7_out_display_pkg.sv
// Shared definitions for the Ben CPU output display: segment codes,
// the segment encoder and the binary-to-BCD converter state type.
package ben_cpu_pkg;

  localparam int NUM_DIGITS = 3;

  // Common-anode codes, active-low, decimal point (bit 7) off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  // Non-decimal nibbles cannot come out of the converter; show them blank.
  function automatic logic [7:0] seg_encode(input logic [3:0] bcd, input logic blank);
    logic [7:0] seg;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
    return seg;
  endfunction

endpackage

// File: rtl/seg7_out_display_if.sv
// CPU OUT-register side of the display block plus the board-facing outputs.
interface seg7_out_display_if;
  import ben_cpu_pkg::*;

  logic                  i_out_load;
  logic [7:0]            i_out_data;
  logic                  o_busy;
  logic [7:0]            o_seg;
  logic [NUM_DIGITS-1:0] o_seg_en;

  modport master (output i_out_load, i_out_data, input o_busy, o_seg, o_seg_en);
  modport slave  (input i_out_load, i_out_data, output o_busy, o_seg, o_seg_en);
endinterface

// File: rtl/seg7_out_display_bin2bcd_seq.sv
// Sequential double-dabble converter, 8-bit binary to 3 BCD digits.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | waiting for start
//   ST_SHIFT  | one add-3/shift iteration per cycle, 8 in total
//   ST_COMMIT | bcd is final for one cycle; start here chains a new job
module bin2bcd_seq
  import ben_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  data,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state, state_nxt;
  logic [19:0] sr, sr_nxt;
  logic [2:0]  iter, iter_nxt;
  logic [11:0] bcd_adj;

  // Add 3 to every BCD nibble of 5 or more ahead of the shift.
  always_comb begin
    bcd_adj[3:0]   = (sr[11:8]  >= 4'd5) ? sr[11:8]  + 4'd3 : sr[11:8];
    bcd_adj[7:4]   = (sr[15:12] >= 4'd5) ? sr[15:12] + 4'd3 : sr[15:12];
    bcd_adj[11:8]  = (sr[19:16] >= 4'd5) ? sr[19:16] + 4'd3 : sr[19:16];
  end

  // Next state, shift register and iteration down-counter.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    iter_nxt  = iter;
    case (state)
      ST_IDLE: begin
        if (start) begin
          sr_nxt    = {12'd0, data};
          iter_nxt  = 3'd7;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_nxt = {bcd_adj[10:0], sr[7:0], 1'b0};
        if (iter == 3'd0) begin
          state_nxt = ST_COMMIT;
        end else begin
          iter_nxt = iter - 3'd1;
        end
      end
      ST_COMMIT: begin
        if (start) begin
          sr_nxt    = {12'd0, data};
          iter_nxt  = 3'd7;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sr    <= '0;
      iter  <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      iter  <= iter_nxt;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_COMMIT);
  assign bcd  = sr[19:8];

endmodule

// File: rtl/seg7_out_display.sv
// Captures CPU OUT-register writes, converts them to decimal and scans
// the three digits onto the common-anode seven-segment display.
module seg7_out_display
  import ben_cpu_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  seg7_out_display_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [1:0]       IDX_LAST = 2'(NUM_DIGITS - 1);

  logic                  conv_start, conv_busy, conv_done;
  logic [11:0]           conv_bcd;
  logic [7:0]            start_data;
  logic                  pend;
  logic [7:0]            pend_data;
  logic [11:0]           disp_bcd;
  logic [CNT_W-1:0]      refresh_cnt;
  logic [1:0]            scan_idx;
  logic [3:0]            digit;
  logic                  blank;
  logic [7:0]            seg_nxt, seg_q;
  logic [NUM_DIGITS-1:0] en_nxt, en_q;

  // A load arriving in COMMIT is newer than any pending byte, so it wins.
  assign conv_start = (bus.i_out_load && !conv_busy) || (conv_done && (pend || bus.i_out_load));
  assign start_data = bus.i_out_load ? bus.i_out_data : pend_data;

  bin2bcd_seq u_conv (
    .clk   (i_clk),
    .rst_n (i_rst),
    .start (conv_start),
    .data  (start_data),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // One-deep pending slot for loads that land mid-conversion (last wins).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pend      <= 1'b0;
      pend_data <= '0;
    end else if (conv_done) begin
      pend <= 1'b0;
    end else if (bus.i_out_load && conv_busy) begin
      pend      <= 1'b1;
      pend_data <= bus.i_out_data;
    end
  end

  // Latch the finished conversion into the display registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      disp_bcd <= '0;
    end else if (conv_done) begin
      disp_bcd <= conv_bcd;
    end
  end

  // Refresh timer and scan index.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == IDX_LAST) ? 2'd0 : scan_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Pick the scanned digit, its leading-zero blanking and its enable.
  always_comb begin
    digit  = disp_bcd[3:0];
    blank  = 1'b0;
    en_nxt = 3'b110;
    case (scan_idx)
      2'd1: begin
        digit  = disp_bcd[7:4];
        blank  = BLANK_ZEROS && (disp_bcd[11:4] == 8'd0);
        en_nxt = 3'b101;
      end
      2'd2: begin
        digit  = disp_bcd[11:8];
        blank  = BLANK_ZEROS && (disp_bcd[11:8] == 4'd0);
        en_nxt = 3'b011;
      end
      default: ;
    endcase
    seg_nxt = seg_encode(digit, blank);
  end

  // Segments and enable move together so no digit shows another's pattern.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      seg_q <= SEG_BLANK;
      en_q  <= '1;
    end else begin
      seg_q <= seg_nxt;
      en_q  <= en_nxt;
    end
  end

  assign bus.o_busy   = conv_busy;
  assign bus.o_seg    = seg_q;
  assign bus.o_seg_en = en_q;

endmodule

// File: tb/tb_seg7_out_display.sv
// Bench for seg7_out_display: one blanking and one non-blanking instance
// share the stimulus; commits are scored against a queue of expected values.
module tb_seg7_out_display;

  localparam int DIV = 4;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       load_r = 1'b0;
  logic [7:0] data_r = 8'd0;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  int sched_val[4];
  int sched_at[4];
  int sched_n;

  typedef struct {
    int         val;
    logic [7:0] u, t, h, tn, hn;
  } vec_t;
  vec_t vecs[9];

  seg7_out_display_if bus_b ();
  seg7_out_display_if bus_n ();

  assign bus_b.i_out_load = load_r;
  assign bus_b.i_out_data = data_r;
  assign bus_n.i_out_load = load_r;
  assign bus_n.i_out_data = data_r;

  seg7_out_display #(.REFRESH_DIV(DIV), .BLANK_ZEROS(1'b1)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus_b)
  );

  seg7_out_display #(.REFRESH_DIV(DIV), .BLANK_ZEROS(1'b0)) dut_nb (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus_n)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every commit must match the next expected decimal value.
  always @(negedge clk) begin
    if (rst_n && dut.conv_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL commit_unexpected: got %0h expected no commit", dut.conv_bcd);
      end else begin
        int v;
        logic [11:0] e;
        v = exp_q.pop_front();
        e = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        check($sformatf("commit_bcd_%0d", v), 32'(dut.conv_bcd), 32'(e));
      end
    end
  end

  // Drive the scheduled loads (cycle offsets from the first) and measure
  // how long busy stays high without a gap.
  task automatic run_seq(output int busy_len);
    bit seen_low;
    busy_len = 0;
    seen_low = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      if (c > 0) begin
        if (!seen_low && bus_b.o_busy) busy_len++;
        else seen_low = 1'b1;
      end
      load_r = 1'b0;
      for (int k = 0; k < sched_n; k++) begin
        if (sched_at[k] == c) begin
          load_r = 1'b1;
          data_r = 8'(sched_val[k]);
        end
      end
      if (seen_low) break;
      @(negedge clk);
    end
    load_r = 1'b0;
  endtask

  // Watch one full scan of both instances and collect each digit's segments.
  task automatic read_disp(output logic [7:0] u_b, t_b, h_b, u_n, t_n, h_n);
    int bad;
    bad = 0;
    u_b = 8'h00; t_b = 8'h00; h_b = 8'h00;
    u_n = 8'h00; t_n = 8'h00; h_n = 8'h00;
    @(negedge clk);
    repeat (3 * DIV) begin
      @(negedge clk);
      case (bus_b.o_seg_en)
        3'b110:  u_b = bus_b.o_seg;
        3'b101:  t_b = bus_b.o_seg;
        3'b011:  h_b = bus_b.o_seg;
        default: bad++;
      endcase
      case (bus_n.o_seg_en)
        3'b110:  u_n = bus_n.o_seg;
        3'b101:  t_n = bus_n.o_seg;
        3'b011:  h_n = bus_n.o_seg;
        default: bad++;
      endcase
    end
    check("seg_en_onehot", 32'(bad), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"},     32'(bus_b.o_seg),    32'hFF);
    check({tag, "_seg_en"},  32'(bus_b.o_seg_en), 32'h7);
    check({tag, "_busy"},    32'(bus_b.o_busy),   32'h0);
    check({tag, "_seg_nb"},  32'(bus_n.o_seg),    32'hFF);
    check({tag, "_en_nb"},   32'(bus_n.o_seg_en), 32'h7);
  endtask

  task automatic check_first_scan(input string tag);
    check({tag, "_first_en"},  32'(bus_b.o_seg_en), 32'h6);
    check({tag, "_first_seg"}, 32'(bus_b.o_seg),    32'hC0);
  endtask

  initial begin
    logic [7:0] u_b, t_b, h_b, u_n, t_n, h_n;
    int bl;

    vecs[0] = '{0,   8'hC0, 8'hFF, 8'hFF, 8'hC0, 8'hC0};
    vecs[1] = '{7,   8'hF8, 8'hFF, 8'hFF, 8'hC0, 8'hC0};
    vecs[2] = '{9,   8'h90, 8'hFF, 8'hFF, 8'hC0, 8'hC0};
    vecs[3] = '{10,  8'hC0, 8'hF9, 8'hFF, 8'hF9, 8'hC0};
    vecs[4] = '{42,  8'hA4, 8'h99, 8'hFF, 8'h99, 8'hC0};
    vecs[5] = '{99,  8'h90, 8'h90, 8'hFF, 8'h90, 8'hC0};
    vecs[6] = '{100, 8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hF9};
    vecs[7] = '{205, 8'h92, 8'hC0, 8'hA4, 8'hC0, 8'hA4};
    vecs[8] = '{255, 8'h92, 8'h92, 8'hA4, 8'h92, 8'hA4};

    // Reset and release.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_first_scan("reset");
    read_disp(u_b, t_b, h_b, u_n, t_n, h_n);
    check("reset_units", 32'(u_b), 32'hC0);
    check("reset_tens",  32'(t_b), 32'hFF);
    check("reset_hund",  32'(h_b), 32'hFF);

    // Single loads from the vector table.
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(vecs[i].val);
      sched_val[0] = vecs[i].val; sched_at[0] = 0; sched_n = 1;
      run_seq(bl);
      check($sformatf("busy_len_%0d", vecs[i].val), 32'(bl), 32'd9);
      read_disp(u_b, t_b, h_b, u_n, t_n, h_n);
      check($sformatf("units_%0d", vecs[i].val),    32'(u_b), 32'(vecs[i].u));
      check($sformatf("tens_%0d", vecs[i].val),     32'(t_b), 32'(vecs[i].t));
      check($sformatf("hund_%0d", vecs[i].val),     32'(h_b), 32'(vecs[i].h));
      check($sformatf("units_nb_%0d", vecs[i].val), 32'(u_n), 32'(vecs[i].u));
      check($sformatf("tens_nb_%0d", vecs[i].val),  32'(t_n), 32'(vecs[i].tn));
      check($sformatf("hund_nb_%0d", vecs[i].val),  32'(h_n), 32'(vecs[i].hn));
    end

    // Back-to-back: 42 is overwritten by 200 while 100 converts.
    exp_q.push_back(100);
    exp_q.push_back(200);
    sched_val[0] = 100; sched_at[0] = 0;
    sched_val[1] = 42;  sched_at[1] = 2;
    sched_val[2] = 200; sched_at[2] = 5;
    sched_n = 3;
    run_seq(bl);
    check("b2b_busy_len", 32'(bl), 32'd18);
    read_disp(u_b, t_b, h_b, u_n, t_n, h_n);
    check("b2b_units", 32'(u_b), 32'hC0);
    check("b2b_tens",  32'(t_b), 32'hC0);
    check("b2b_hund",  32'(h_b), 32'hA4);

    // Load landing exactly on the COMMIT edge chains without a gap.
    exp_q.push_back(50);
    exp_q.push_back(60);
    sched_val[0] = 50; sched_at[0] = 0;
    sched_val[1] = 60; sched_at[1] = 9;
    sched_n = 2;
    run_seq(bl);
    check("commit_load_busy_len", 32'(bl), 32'd18);
    read_disp(u_b, t_b, h_b, u_n, t_n, h_n);
    check("commit_load_units", 32'(u_b), 32'hC0);
    check("commit_load_tens",  32'(t_b), 32'h82);
    check("commit_load_hund",  32'(h_b), 32'hFF);

    // Reset in the middle of converting 123.
    @(negedge clk);
    load_r = 1'b1; data_r = 8'd123;
    @(negedge clk);
    load_r = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy_before", 32'(bus_b.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_first_scan("midrst");
    read_disp(u_b, t_b, h_b, u_n, t_n, h_n);
    check("midrst_units", 32'(u_b), 32'hC0);
    check("midrst_tens",  32'(t_b), 32'hFF);
    check("midrst_hund",  32'(h_b), 32'hFF);
    check("midrst_tens_nb", 32'(t_n), 32'hC0);

    // Exhaustive sweep; commits are scored by the monitor.
    for (int v = 0; v < 256; v++) begin
      exp_q.push_back(v);
      sched_val[0] = v; sched_at[0] = 0; sched_n = 1;
      run_seq(bl);
      check($sformatf("sweep_busy_%0d", v), 32'(bl), 32'd9);
    end
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
